// File: rtl/collision_counter_pkg.sv
// Shared definitions for the pixel-path blocks (pixel_join, collision_counter).
//   - colour constants used by pixel_join
//   - default width of the collision count outputs
//   - popcount_width(): result width of a popcount over a given number of bits
package collision_counter_pkg;

  localparam logic [11:0] BACKGROUND = 12'h000;
  localparam logic [11:0] GREEN      = 12'h0F0;
  localparam logic [11:0] RED        = 12'hF00;
  localparam logic [11:0] BLUE       = 12'h00F;

  // 32 matches the integer-typed port of the game-logic consumer.
  localparam int CNT_W_DEFAULT = 32;

  // Bits needed to hold any value 0..width.
  function automatic int popcount_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/collision_counter_popcount_tree.sv
// Purely combinational balanced adder tree returning the number of set bits.
// Ports:
//   i_bits  [WIDTH-1:0]  input vector
//   o_count [OUT_W-1:0]  number of ones in i_bits, OUT_W = clog2(WIDTH+1)
module collision_counter_popcount_tree
  import collision_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  localparam int OUT_W = popcount_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [OUT_W-1:0] o_count
);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign o_count = i_bits;
    end else begin : g_split
      // Split into two near-equal halves so depth stays log2(WIDTH).
      localparam int LO_W  = WIDTH / 2;
      localparam int HI_W  = WIDTH - LO_W;
      localparam int LO_CW = popcount_width(LO_W);
      localparam int HI_CW = popcount_width(HI_W);

      logic [LO_CW-1:0] w_lo;
      logic [HI_CW-1:0] w_hi;

      collision_counter_popcount_tree #(.WIDTH(LO_W)) u_lo (
        .i_bits  (i_bits[LO_W-1:0]),
        .o_count (w_lo)
      );

      collision_counter_popcount_tree #(.WIDTH(HI_W)) u_hi (
        .i_bits  (i_bits[WIDTH-1:LO_W]),
        .o_count (w_hi)
      );

      // Sum of both halves is at most WIDTH, which always fits OUT_W.
      assign o_count = OUT_W'(w_lo) + OUT_W'(w_hi);
    end
  endgenerate

endmodule

// File: rtl/collision_counter.sv
// Reports how many drawable components drive the current pixel, for hit
// detection in game logic. All outputs are registered (1 cycle latency).
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     per-component "outputting this pixel" flags
//   clear      synchronous clear of the peak register
//   number     registered popcount of enable
//   collision  registered flag, number >= 2
//   peak       highest number since reset or clear
module collision_counter
  import collision_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] enable,
  input  logic             clear,
  output logic [CNT_W-1:0] number,
  output logic             collision,
  output logic [CNT_W-1:0] peak
);

  localparam int PC_W = popcount_width(WIDTH);

  logic [WIDTH-1:0] w_enable_clean;
  logic [PC_W-1:0]  w_count;
  logic [CNT_W-1:0] w_count_ext;

  logic [CNT_W-1:0] r_number;
  logic             r_collision;
  logic [CNT_W-1:0] r_peak;

  // Unknown/undriven bits count as "not driving" so X never reaches outputs.
  always_comb begin
    w_enable_clean = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_enable_clean[i] = (enable[i] === 1'b1);
    end
  end

  collision_counter_popcount_tree #(.WIDTH(WIDTH)) u_popcount_tree (
    .i_bits  (w_enable_clean),
    .o_count (w_count)
  );

  assign w_count_ext = CNT_W'(w_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_number    <= '0;
      r_collision <= 1'b0;
      r_peak      <= '0;
    end else begin
      r_number    <= w_count_ext;
      r_collision <= (w_count_ext >= CNT_W'(2));
      // Clear restarts tracking from the current sample rather than zero.
      if (clear) begin
        r_peak <= w_count_ext;
      end else if (w_count_ext > r_peak) begin
        r_peak <= w_count_ext;
      end
    end
  end

  assign number    = r_number;
  assign collision = r_collision;
  assign peak      = r_peak;

endmodule

// File: tb/tb_collision_counter.sv
module tb_collision_counter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  enable_a;
  logic        clear_a;
  logic [31:0] number_a;
  logic        collision_a;
  logic [31:0] peak_a;

  logic [7:0]  enable_b;
  logic        clear_b;
  logic [31:0] number_b;
  logic        collision_b;
  logic [31:0] peak_b;

  logic [3:0]  enable_c;
  logic        clear_c;
  logic [31:0] number_c;
  logic        collision_c;
  logic [31:0] peak_c;

  int n_checks;
  int n_errors;

  collision_counter #(.WIDTH(2)) u_dut_w2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable_a),
    .clear     (clear_a),
    .number    (number_a),
    .collision (collision_a),
    .peak      (peak_a)
  );

  collision_counter #(.WIDTH(8)) u_dut_w8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable_b),
    .clear     (clear_b),
    .number    (number_b),
    .collision (collision_b),
    .peak      (peak_b)
  );

  collision_counter #(.WIDTH(4)) u_dut_w4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable_c),
    .clear     (clear_c),
    .number    (number_c),
    .collision (collision_c),
    .peak      (peak_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: enable value, expected number, expected collision.
  logic [1:0] vec_a_en [4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
  int         vec_a_num [4]  = '{0, 1, 1, 2};
  logic       vec_a_col [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [7:0] vec_b_en [3]   = '{8'hFF, 8'hA5, 8'h80};
  int         vec_b_num [3]  = '{8, 4, 1};
  logic       vec_b_col [3]  = '{1'b1, 1'b1, 1'b0};

  // Peak sequence: enable, clear, expected number, expected peak.
  logic [7:0] pk_en [5]      = '{8'h03, 8'h1F, 8'h01, 8'h01, 8'h07};
  logic       pk_clr [5]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int         pk_num [5]     = '{2, 5, 1, 1, 3};
  int         pk_peak [5]    = '{2, 5, 5, 1, 3};

  initial begin
    int exp_cnt;
    int exp_peak;
    logic [3:0] en_r;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    enable_a = 2'b11;
    enable_b = 8'hFF;
    enable_c = 4'hF;
    clear_a  = 1'b0;
    clear_b  = 1'b0;
    clear_c  = 1'b0;

    // Held reset with everything enabled: outputs stay at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_hold_number", number_a, 0);
      check_val("rst_hold_collision", collision_a, 0);
      check_val("rst_hold_peak", peak_a, 0);
      check_val("rst_hold_number_w8", number_b, 0);
    end
    rst_n = 1'b1;

    tick();
    check_val("pre_async_number", number_a, 2);
    check_val("pre_async_collision", collision_a, 1);
    check_val("pre_async_peak", peak_a, 2);

    // Asynchronous reset in the middle of the cycle, before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_number", number_a, 0);
    check_val("async_rst_collision", collision_a, 0);
    check_val("async_rst_peak", peak_a, 0);
    check_val("async_rst_number_w8", number_b, 0);
    enable_a = 2'b01;
    rst_n = 1'b1;

    // First edge after release loads a normal count.
    tick();
    check_val("post_rst_number", number_a, 1);
    check_val("post_rst_peak", peak_a, 1);

    for (int i = 0; i < 4; i++) begin
      enable_a = vec_a_en[i];
      tick();
      check_val("w2_number", number_a, vec_a_num[i]);
      check_val("w2_collision", collision_a, vec_a_col[i]);
    end
    check_val("w2_peak", peak_a, 2);

    for (int i = 0; i < 3; i++) begin
      enable_b = vec_b_en[i];
      tick();
      check_val("w8_number", number_b, vec_b_num[i]);
      check_val("w8_collision", collision_b, vec_b_col[i]);
    end

    // Peak of WIDTH=8 instance is 8 from earlier; clear restarts it.
    for (int i = 0; i < 5; i++) begin
      enable_b = pk_en[i];
      clear_b  = pk_clr[i];
      tick();
      check_val("w8_peak_number", number_b, pk_num[i]);
      check_val("w8_peak", peak_b, pk_peak[i]);
    end
    clear_b = 1'b0;

    // Latency and coherence with random vectors on WIDTH=4.
    exp_peak = 0;
    for (int i = 0; i < 1000; i++) begin
      en_r     = 4'($urandom_range(0, 15));
      enable_c = en_r;
      clear_c  = (i == 0);
      exp_cnt  = $countones(en_r);
      if (i == 0 || exp_cnt > exp_peak) exp_peak = exp_cnt;
      tick();
      check_val("w4_rand_number", number_c, exp_cnt);
      check_val("w4_rand_collision", collision_c, (exp_cnt >= 2) ? 1 : 0);
      check_val("w4_rand_peak", peak_c, exp_peak);
    end
    clear_c = 1'b0;

    // Unknown bit counts as 0.
    enable_c = 4'b1x01;
    tick();
    check_val("x_number", number_c, 2);
    check_val("x_collision", collision_c, 1);
    check_val("x_no_unknown", $isunknown({number_c, collision_c, peak_c}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/collision_counter.md
Name: collision_counter

Overview:
- Counts how many drawable components are driving a pixel at the same time, i.e. the population count of the per-component enable vector.
- Sits beside pixel_join in the pixel path. pixel_join selects the winning pixel; this block reports the collision count for game logic (hit detection).
- Output is registered: one clock of latency relative to the enable vector.

Parameters:
- WIDTH, default 2: number of component enable inputs; legal range 1..1024.
- CNT_W, default 32: width of the count outputs; 32 matches the integer-typed consumer port.

Ports:
- clk  input  1  pixel clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  WIDTH  bit i is 1 when component i is outputting at the current pixel.
- clear  input  1  synchronous clear of the peak register.
- number  output  CNT_W  registered count of set bits in enable.
- collision  output  1  registered flag, 1 when the registered count is 2 or more.
- peak  output  CNT_W  highest number value since reset or clear.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - number = 0, collision = 0, peak = 0.
  - Outputs hold these values for as long as rst_n is low.
- Count:
  - Each rising edge, number <= popcount(enable), zero-extended to CNT_W.
  - Count is unsigned; the maximum is WIDTH, which always fits in CNT_W. No saturation or wrap logic is needed.
- Latency: number and collision reflect the enable vector sampled on the previous edge, exactly 1 cycle.
- Collision flag:
  - collision <= (popcount(enable) >= 2), computed from the same sampled vector as number.
  - Flag and count are always coherent in the same cycle.
  - A single enabled component is not a collision.
- Peak:
  - Each edge, peak <= max(peak, popcount(enable)).
  - When clear is 1 on an edge, peak <= popcount(enable) of that same edge; clear wins over the hold path, but the current sample still counts.
- Input handling:
  - Unknown or undriven enable bits are treated as 0 in simulation (X-safe reduction).
  - Inputs are sampled only on clock edges; no combinational path from enable to any output.
- Reset released mid-frame: the first edge after rst_n rises loads a normal count; there are no warm-up cycles.
- Implementation: a balanced adder tree is allowed. The whole reduction must close timing in one cycle at the pixel clock for WIDTH up to 64. For larger WIDTH, the designer may add pipeline stages only through a new LATENCY parameter, defaulting to 1.

Decomposition:
- Shared package/header (constants.vh):
  - colour constants, including BACKGROUND/GREEN, already used by pixel_join;
  - the CNT_W default;
  - a function returning the bit width for a WIDTH-bit popcount.
- One natural sub-module: popcount_tree, a purely combinational parameterised adder tree (WIDTH in, clog2(WIDTH+1) bits out), instantiated once.
- Registers, the collision compare and the peak logic stay in collision_counter.

Test Plan:
- Reset: hold rst_n=0 with enable=2'b11 for 3 cycles -> number=0, collision=0, peak=0 throughout. Assert rst_n=0 asynchronously mid-cycle -> outputs go to 0 before the next edge.
- Basic count, WIDTH=2: enable 00, 01, 10, 11 on successive edges -> number 0, 1, 1, 2 one cycle later; collision 0, 0, 0, 1.
- Wide count, WIDTH=8: enable 8'hFF then 8'hA5 then 8'h80 -> number 8, 4, 1; collision 1, 1, 0.
- Peak and clear, WIDTH=8:
  - enable 8'h03, 8'h1F, 8'h01 -> peak 2, 5, 5.
  - Then clear=1 with enable 8'h01 -> peak 1; next edge with enable 8'h07 -> peak 3.
- Latency and coherence, WIDTH=4: random enable for 1000 cycles -> number equals popcount of the previous-cycle enable; collision equals (number >= 2) in every cycle.
- X handling, WIDTH=4: enable 4'b1X01 -> number=2 with no X on any output.
